snake_head_ctrl: RTL and testbench
==================================

Name: snake_head_ctrl

Overview:
- Drives the snake's head position, sub-grid step counter, committed direction and length, once per frame.
- Its outputs feed the body/trail renderer.
- Inputs are the debounced direction buttons, pause, the food-eaten pulse and the self-collision flag.
- It detects wall and self collisions and holds the game in a sticky dead state until reset.

Parameters:
- SIZE, 10, link size in pixels; also the number of frames per grid step.
- START_X, 320, head_x after reset.
- START_Y, 240, head_y after reset.
- START_LEN, 3, length after reset.
- MAX_LEN, 1000, length saturation value.
- WALL_MIN_X / WALL_MAX_X, 10 / 620, legal head_x range, inclusive.
- WALL_MIN_Y / WALL_MAX_Y, 10 / 460, legal head_y range, inclusive.

Ports:
- v_sync  in  1  clock, one rising edge per frame
- reset  in  1  synchronous, active-high; 1 = reset
- pause  in  1  level; 1 = freeze game state
- btn_up, btn_left, btn_right, btn_down  in  1 each  debounced level inputs
- food_eaten  in  1  one-frame pulse from the food block
- self_hit  in  1  head overlaps body, sampled each edge
- head_x, head_y  out  10 each  head pixel position
- count  out  4  sub-grid step, 1..SIZE
- next_direction  out  3  committed direction: 000 up, 001 left, 010 right, 011 down
- length  out  13  snake length in links
- head_death  out  1  sticky death flag

Behaviour:
- One clock domain (v_sync); reset is synchronous and active-high. All state updates on the v_sync rising edge.
- Reset values:
  - head_x = START_X, head_y = START_Y
  - count = 0, next_direction = 010 (right), length = START_LEN
  - head_death = 0, pending_dir = 010, grow_pending = 0
  - state = RUN
- FSM states: RUN, PAUSED, DEAD.
  - RUN -> PAUSED when pause = 1.
  - PAUSED -> RUN when pause = 0.
  - RUN -> DEAD on a collision.
  - DEAD is exited only by reset.
  - In PAUSED and DEAD, head_x, head_y, count, next_direction and length all hold.
- Direction capture (RUN and PAUSED):
  - Each edge, the highest-priority pressed button is taken; priority is up > left > right > down.
  - It is written to pending_dir unless it is the exact opposite of next_direction. Reversals are ignored.
  - With no button pressed, pending_dir holds.
- RUN edge, in order:
  - dir = (count == SIZE) ? pending_dir : next_direction.
  - next_direction <= dir.
  - count <= (count == SIZE) ? 1 : count + 1. Count 0 occurs only after reset; the first run edge gives 1.
  - Candidate head = head moved 1 pixel in dir. Up = y-1, down = y+1, left = x-1, right = x+1.
- Collision:
  - Wall hit: candidate outside the inclusive WALL range on either axis.
  - Self hit: self_hit = 1 on this edge.
  - On a collision, state <= DEAD and head_death <= 1; head and count do not update on that edge.
  - Otherwise the head takes the candidate value.
- Growth:
  - A food_eaten pulse increments grow_pending (4-bit, saturates at 15). It is accepted in RUN and PAUSED and ignored in DEAD.
  - On a RUN edge with count == SIZE and grow_pending > 0: length <= min(length + 1, MAX_LEN) and grow_pending decrements.
  - If food_eaten and consumption fall on the same edge, grow_pending is unchanged (net +1 -1).
- Reset asserted mid-game, in any state, restores all reset values on that edge.
- pause and reset both high: reset wins.
- Width rules: all position arithmetic is 10-bit unsigned. Wall checks must happen before any wrap can occur (WALL_MIN >= 1).

Test Plan:
- Reset, then 10 running frames -> count runs 1..10, head_x runs 321..330, head_y = 240, next_direction = 010, length = 3.
- Press btn_up at count = 4 -> next_direction stays 010 until the edge where count = 10; on that edge it becomes 000, head_y decrements from then on, count returns to 1.
- Heading right, press btn_left -> ignored; pending_dir and next_direction stay 010 across the grid boundary.
- Two food_eaten pulses 3 frames apart -> length 3 -> 4 at the next count = 10 edge, -> 5 at the following one; grow_pending ends at 0.
- Run right from head_x = 615 -> head stops at 620, head_death = 1 on the edge where the candidate is 621, state DEAD; buttons, pause and food are then ignored; reset restores (320, 240), length 3, death 0.
- pause = 1 for 5 frames mid-step at count = 6 -> all outputs hold; after release count continues 7, 8, ...; reset asserted together with pause -> reset values.

Source files
------------

// File: rtl/snake_head_ctrl_if.sv
// Bundle of the snake head controller's game-side inputs and renderer-side outputs.
// The master drives buttons/pause/food/self_hit; the slave (controller) drives the head state.
interface snake_head_ctrl_if;
  logic        i_pause;
  logic        i_btn_up;
  logic        i_btn_left;
  logic        i_btn_right;
  logic        i_btn_down;
  logic        i_food_eaten;
  logic        i_self_hit;
  logic [9:0]  o_head_x;
  logic [9:0]  o_head_y;
  logic [3:0]  o_count;
  logic [2:0]  o_next_direction;
  logic [12:0] o_length;
  logic        o_head_death;

  modport master (
    output i_pause, i_btn_up, i_btn_left, i_btn_right, i_btn_down, i_food_eaten, i_self_hit,
    input  o_head_x, o_head_y, o_count, o_next_direction, o_length, o_head_death
  );

  modport slave (
    input  i_pause, i_btn_up, i_btn_left, i_btn_right, i_btn_down, i_food_eaten, i_self_hit,
    output o_head_x, o_head_y, o_count, o_next_direction, o_length, o_head_death
  );
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake head controller: per-frame head movement, direction commit at grid boundaries,
// growth bookkeeping and sticky wall/self collision detection.
module snake_head_ctrl #(
  parameter int SIZE       = 10,
  parameter int START_X    = 320,
  parameter int START_Y    = 240,
  parameter int START_LEN  = 3,
  parameter int MAX_LEN    = 1000,
  parameter int WALL_MIN_X = 10,
  parameter int WALL_MAX_X = 620,
  parameter int WALL_MIN_Y = 10,
  parameter int WALL_MAX_Y = 460
) (
  input  logic              i_v_sync,
  input  logic              i_reset,
  snake_head_ctrl_if.slave  bus
);

  // state | meaning
  // RUN    | head advances one pixel per frame
  // PAUSED | all game state frozen, direction and food still captured
  // DEAD   | collision seen, frozen until reset
  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_DEAD} state_t;

  localparam logic [3:0]  SIZE_C  = 4'(SIZE);
  localparam logic [9:0]  SX      = 10'(START_X);
  localparam logic [9:0]  SY      = 10'(START_Y);
  localparam logic [12:0] SLEN    = 13'(START_LEN);
  localparam logic [12:0] LEN_MAX = 13'(MAX_LEN);
  localparam logic [9:0]  XMIN    = 10'(WALL_MIN_X);
  localparam logic [9:0]  XMAX    = 10'(WALL_MAX_X);
  localparam logic [9:0]  YMIN    = 10'(WALL_MIN_Y);
  localparam logic [9:0]  YMAX    = 10'(WALL_MAX_Y);
  localparam logic [2:0]  DIR_UP = 3'd0, DIR_LEFT = 3'd1, DIR_RIGHT = 3'd2, DIR_DOWN = 3'd3;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_head_x, r_head_y, w_cand_x, w_cand_y;
  logic [3:0]  r_count, r_grow;
  logic [2:0]  r_next_dir, r_pending_dir, w_dir, w_btn_dir;
  logic [12:0] r_length;
  logic        r_death;
  logic        w_btn_valid, w_step, w_wrap, w_wall, w_collide, w_consume, w_food;

  assign w_step    = (r_state == ST_RUN) && !bus.i_pause;
  assign w_wrap    = (r_count == SIZE_C);
  assign w_dir     = w_wrap ? r_pending_dir : r_next_dir;
  assign w_wall    = (w_cand_x < XMIN) || (w_cand_x > XMAX) || (w_cand_y < YMIN) || (w_cand_y > YMAX);
  assign w_collide = w_step && (w_wall || bus.i_self_hit);
  assign w_consume = w_step && w_wrap && (r_grow != 4'd0);
  assign w_food    = bus.i_food_eaten && (r_state != ST_DEAD);

  always_comb begin
    w_state_nxt = r_state;
    w_btn_valid = 1'b1;
    w_btn_dir   = DIR_RIGHT;
    w_cand_x    = r_head_x;
    w_cand_y    = r_head_y;
    case (r_state)
      ST_RUN:    if (bus.i_pause) w_state_nxt = ST_PAUSED;
                 else if (w_collide) w_state_nxt = ST_DEAD;
      ST_PAUSED: if (!bus.i_pause) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_DEAD;
    endcase
    if (bus.i_btn_up)         w_btn_dir = DIR_UP;
    else if (bus.i_btn_left)  w_btn_dir = DIR_LEFT;
    else if (bus.i_btn_right) w_btn_dir = DIR_RIGHT;
    else if (bus.i_btn_down)  w_btn_dir = DIR_DOWN;
    else                      w_btn_valid = 1'b0;
    // Walls sit at >= 1, so x-1 / y-1 of a legal head never wraps.
    case (w_dir)
      DIR_UP:    w_cand_y = r_head_y - 10'd1;
      DIR_LEFT:  w_cand_x = r_head_x - 10'd1;
      DIR_RIGHT: w_cand_x = r_head_x + 10'd1;
      default:   w_cand_y = r_head_y + 10'd1;
    endcase
  end

  always_ff @(posedge i_v_sync) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_head_x      <= SX;
      r_head_y      <= SY;
      r_count       <= 4'd0;
      r_next_dir    <= DIR_RIGHT;
      r_pending_dir <= DIR_RIGHT;
      r_length      <= SLEN;
      r_grow        <= 4'd0;
      r_death       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Up/down and left/right codes sum to 3, so that identifies a reversal.
      if ((r_state != ST_DEAD) && w_btn_valid && (w_btn_dir != (3'd3 - r_next_dir)))
        r_pending_dir <= w_btn_dir;
      if (w_food && !w_consume && (r_grow != 4'd15)) r_grow <= r_grow + 4'd1;
      else if (!w_food && w_consume)                 r_grow <= r_grow - 4'd1;
      if (w_step) begin
        r_next_dir <= w_dir;
        if (w_consume) r_length <= (r_length >= LEN_MAX) ? LEN_MAX : r_length + 13'd1;
        if (w_collide) begin
          r_death <= 1'b1;
        end else begin
          r_head_x <= w_cand_x;
          r_head_y <= w_cand_y;
          r_count  <= w_wrap ? 4'd1 : r_count + 4'd1;
        end
      end
    end
  end

  assign bus.o_head_x         = r_head_x;
  assign bus.o_head_y         = r_head_y;
  assign bus.o_count          = r_count;
  assign bus.o_next_direction = r_next_dir;
  assign bus.o_length         = r_length;
  assign bus.o_head_death     = r_death;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: directed game scenarios then random play, every frame
// compared against a plain arithmetic model of the game rules.
module tb_snake_head_ctrl;
  localparam int SIZE = 10;
  localparam int M_RUN = 0, M_PAUSE = 1, M_DEAD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_x, m_y, m_cnt, m_nd, m_pd, m_len, m_grow, m_death, m_mode;

  snake_head_ctrl_if bus ();

  snake_head_ctrl dut (
    .i_v_sync (clk),
    .i_reset  (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("comparison %s differs", tag);
    end
  endtask

  task automatic model_edge();
    int b, dir, nx, ny, new_pd;
    bit moving, wrap, consume, food_ok, hit;
    if (reset) begin
      m_x = 320; m_y = 240; m_cnt = 0; m_nd = 2; m_pd = 2;
      m_len = 3; m_grow = 0; m_death = 0; m_mode = M_RUN;
      return;
    end
    moving  = (m_mode == M_RUN) && !bus.i_pause;
    wrap    = (m_cnt == SIZE);
    food_ok = bus.i_food_eaten && (m_mode != M_DEAD);
    consume = moving && wrap && (m_grow > 0);
    b = -1;
    if (bus.i_btn_up)         b = 0;
    else if (bus.i_btn_left)  b = 1;
    else if (bus.i_btn_right) b = 2;
    else if (bus.i_btn_down)  b = 3;
    new_pd = (m_mode != M_DEAD && b >= 0 && b + m_nd != 3) ? b : m_pd;
    if (moving) begin
      dir = wrap ? m_pd : m_nd;
      nx = m_x + int'(dir == 2) - int'(dir == 1);
      ny = m_y + int'(dir == 3) - int'(dir == 0);
      hit = (nx < 10) || (nx > 620) || (ny < 10) || (ny > 460) || bus.i_self_hit;
      m_nd = dir;
      if (consume) m_len = (m_len + 1 > 1000) ? 1000 : m_len + 1;
      if (hit) begin
        m_death = 1; m_mode = M_DEAD;
      end else begin
        m_x = nx; m_y = ny; m_cnt = wrap ? 1 : m_cnt + 1;
      end
    end else if (m_mode == M_RUN && bus.i_pause) begin
      m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE && !bus.i_pause) begin
      m_mode = M_RUN;
    end
    if (food_ok && !consume) m_grow = (m_grow == 15) ? 15 : m_grow + 1;
    else if (!food_ok && consume) m_grow = m_grow - 1;
    m_pd = new_pd;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("head_x", 16'(bus.o_head_x), 16'(m_x));
    chk("head_y", 16'(bus.o_head_y), 16'(m_y));
    chk("count", 16'(bus.o_count), 16'(m_cnt));
    chk("next_direction", 16'(bus.o_next_direction), 16'(m_nd));
    chk("length", 16'(bus.o_length), 16'(m_len));
    chk("head_death", 16'(bus.o_head_death), 16'(m_death));
  endtask

  task automatic idle_inputs();
    bus.i_pause = 0; bus.i_btn_up = 0; bus.i_btn_left = 0; bus.i_btn_right = 0;
    bus.i_btn_down = 0; bus.i_food_eaten = 0; bus.i_self_hit = 0;
  endtask

  task automatic run_until_count(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 30) begin step(); k++; end
    chk("reach_count", 16'(bus.o_count), 16'(target));
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    chk("reset_x", 16'(bus.o_head_x), 16'd320);
    chk("reset_count", 16'(bus.o_count), 16'd0);

    // Ten free-running frames heading right.
    for (int i = 0; i < 10; i++) step();
    chk("ten_frames_x", 16'(bus.o_head_x), 16'd330);

    // Turn up pressed mid-step; commits at the grid boundary.
    run_until_count(4);
    bus.i_btn_up = 1; step(); bus.i_btn_up = 0;
    for (int i = 0; i < 10; i++) step();
    chk("turned_up", 16'(bus.o_next_direction), 16'd0);

    // Turn right, then hold a reversal (left) across a boundary.
    bus.i_btn_right = 1; step(); bus.i_btn_right = 0;
    for (int i = 0; i < 12; i++) step();
    bus.i_btn_left = 1;
    for (int i = 0; i < 12; i++) step();
    bus.i_btn_left = 0;
    chk("reversal_ignored", 16'(bus.o_next_direction), 16'd2);

    // Two food pulses three frames apart.
    bus.i_food_eaten = 1; step(); bus.i_food_eaten = 0;
    step(); step();
    bus.i_food_eaten = 1; step(); bus.i_food_eaten = 0;
    for (int i = 0; i < 22; i++) step();
    chk("grown_len", 16'(bus.o_length), 16'd5);

    // Run into the right wall, then confirm the dead state ignores everything.
    reset = 1; step(); reset = 0;
    begin
      int k;
      k = 0;
      while (m_mode != M_DEAD && k < 400) begin step(); k++; end
    end
    chk("wall_death", 16'(bus.o_head_death), 16'd1);
    chk("wall_x", 16'(bus.o_head_x), 16'd620);
    for (int i = 0; i < 20; i++) begin
      bus.i_pause = 1'($urandom_range(0, 1));
      bus.i_btn_up = 1'($urandom_range(0, 1));
      bus.i_btn_down = 1'($urandom_range(0, 1));
      bus.i_food_eaten = 1'($urandom_range(0, 1));
      step();
    end
    idle_inputs();
    reset = 1; step(); reset = 0;
    chk("revived_death", 16'(bus.o_head_death), 16'd0);

    // Pause mid-step, release, then pause together with reset.
    run_until_count(6);
    bus.i_pause = 1;
    for (int i = 0; i < 5; i++) step();
    bus.i_pause = 0;
    for (int i = 0; i < 5; i++) step();
    bus.i_pause = 1; reset = 1; step();
    bus.i_pause = 0; reset = 0;
    chk("pause_reset_x", 16'(bus.o_head_x), 16'd320);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 79) == 0);
      bus.i_pause      = ($urandom_range(0, 9) == 0);
      bus.i_btn_up     = ($urandom_range(0, 24) == 0);
      bus.i_btn_left   = ($urandom_range(0, 24) == 0);
      bus.i_btn_right  = ($urandom_range(0, 24) == 0);
      bus.i_btn_down   = ($urandom_range(0, 24) == 0);
      bus.i_food_eaten = ($urandom_range(0, 7) == 0);
      bus.i_self_hit   = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
